gf180mcu_fd_sc_mcu9t5v0__buf_drive_seq: RTL and testbench
=========================================================

# gf180mcu_fd_sc_mcu9t5v0__buf_drive_seq

Staggered output-enable sequencer for a bank of 4x buffer groups. It ramps the groups on one at a time at a programmable spacing, so a large fan-out net is never switched by every driver at once, and it ramps them off in reverse order. It sits between the chip-level drive-enable control and the enable pins of the buffer groups driving a shared heavy net.

## Interface
Parameters:
- N_GRP, 4, number of buffer groups (2..16).
- GAP_W, 8, width of the spacing input.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- VDD  inout  1  power.
- VSS  inout  1  ground.
- EN  input  1  level request: 1 = all groups on, 0 = all groups off.
- FORCE_OFF  input  1  emergency drop of all groups.
- GAP  input  GAP_W  extra cycles between steps; spacing is GAP+1 cycles.
- OE  output  N_GRP  thermometer enable; bit 0 is first on and last off.
- BUSY  output  1  ramp in progress.
- READY  output  1  all groups on and stable.

## Operation
- Internal state:
  - Level L (0..N_GRP), with OE = (1<<L)-1.
  - Step counter, GAP_W bits.
  - GAP latch.
  - FSM with states IDLE (L=0), UP, ON (L=N_GRP) and DOWN.
- Priority on every edge: RST > FORCE_OFF > EN.
- RST: L=0, FSM=IDLE, counter=0, GAP latch=0. Outputs: OE=0, BUSY=0, READY=0.
- FORCE_OFF=1 in any state: next edge gives L=0 and IDLE. There is no ramp.
- IDLE:
  - If EN=1, go to UP.
  - On that same edge: L=1, GAP is latched and the counter is loaded with GAP.
- UP:
  - Counter is non-zero: decrement it.
  - Counter is zero and L<N_GRP-1: L++ and reload the counter with the latched GAP.
  - Counter is zero and L=N_GRP-1: L=N_GRP and go to ON.
- ON:
  - If EN=0, go to DOWN.
  - On that same edge: L=N_GRP-1, GAP is latched and the counter is loaded.
- DOWN:
  - Mirror of UP with L decremented.
  - When L reaches 0, go to IDLE.
- Reversal during UP (EN=0 sampled): go to DOWN. On the same edge L-- and the counter reloads from the current GAP input. If L reaches 0, go straight to IDLE.
- Reversal during DOWN (EN=1 sampled): go to UP. On the same edge L++ and the counter reloads from the current GAP input. If L reaches N_GRP, go straight to ON.
- GAP changes during a ramp have no effect until the next ramp or reversal.
- Outputs:
  - BUSY = (FSM is UP or DOWN).
  - READY = (FSM is ON).
  - All outputs are registered. There is no combinational path from inputs to outputs.
- Invariant: OE is always a thermometer code. Exactly one bit changes per step, except on FORCE_OFF or RST.

## Timing
- Edge 0 is the edge that samples EN=1 in IDLE. OE=1 (group 0 on) is visible after edge 0.
- Group k turns on at edge k*(GAP+1).
- OE becomes all ones and READY rises at edge (N_GRP-1)*(GAP+1).
- BUSY rises with edge 0. It falls on the same edge READY rises.
- Turn-off is symmetric:
  - The edge that samples EN=0 in ON clears READY and OE[N_GRP-1].
  - Group k turns off (N_GRP-1-k)*(GAP+1) edges later.
  - BUSY falls on the edge where OE becomes 0.
- GAP=0 gives one step per clock. GAP=2^GAP_W-1 must not overflow the counter.
- EN held at the same value as the current end state (IDLE with EN=0, ON with EN=1): no activity, and the counter holds.
- FORCE_OFF and a reversal on the same edge: FORCE_OFF wins.
- RST asserted mid-ramp: OE=0 after that edge. Operation resumes from IDLE on the first edge after RST drops.

## Test plan
- N_GRP=4, GAP=2, EN rises at edge 0 → OE = 0001, 0011, 0111, 1111 after edges 0, 3, 6, 9. READY=1 and BUSY=0 after edge 9.
- From ON, EN=0 sampled at edge 20, GAP=2 → OE = 0111, 0011, 0001, 0000 after edges 20, 23, 26, 29. READY=0 after edge 20. BUSY=0 after edge 29.
- Ramp up with GAP=1 and EN dropped at edge 3 (OE=0011) → OE=0001 after edge 3 and OE=0000 after edge 5. Never a non-thermometer value.
- FORCE_OFF pulsed at edge 4 of an up-ramp with EN still 1 → OE=0000 and IDLE after edge 4. A new ramp starts at edge 5: OE=0001 after edge 5.
- GAP=0, then GAP changed to 7 after edge 1 of the ramp → steps stay 1 cycle apart, OE=1111 after edge 3. The next down-ramp uses spacing 8.
- RST asserted at edge 5 of a ramp → OE=0, BUSY=0 and READY=0 after edge 5. With EN=1 still held, OE=0001 on the first edge after RST drops.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__buf_drive_seq.sv
// Staggered output-enable sequencer: ramps buffer groups on one at a time at a
// programmable spacing and ramps them off in reverse order.
module gf180mcu_fd_sc_mcu9t5v0__buf_drive_seq #(
   parameter int N_GRP = 4,
   parameter int GAP_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   inout  wire              VDD,
   inout  wire              VSS,
   input  logic             EN,
   input  logic             FORCE_OFF,
   input  logic [GAP_W-1:0] GAP,
   output logic [N_GRP-1:0] OE,
   output logic             BUSY,
   output logic             READY
);

   typedef enum logic [1:0] {IDLE, UP, ON, DOWN} state_t;

   localparam int LW = $clog2(N_GRP + 1);
   localparam logic [LW-1:0] LVL_ONE = LW'(1);
   localparam logic [LW-1:0] LVL_PEN = LW'(N_GRP - 1);
   localparam logic [LW-1:0] LVL_TOP = LW'(N_GRP);

   state_t             state_q, state_d;
   logic [LW-1:0]      lvl_q, lvl_d;
   logic [GAP_W-1:0]   cnt_q, cnt_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [N_GRP-1:0]   oe_q, oe_d;
   logic               busy_q, busy_d;
   logic               ready_q, ready_d;

   // Power pins only pass through to the netlist; the logic never depends on them.
   wire unusedPower = VDD ^ VSS;

   always_comb begin
      state_d = state_q;
      lvl_d   = lvl_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      if (FORCE_OFF) begin
         state_d = IDLE;
         lvl_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: if (EN) begin
               state_d = UP;
               lvl_d   = LVL_ONE;
               gap_d   = GAP;
               cnt_d   = GAP;
            end
            UP: if (!EN) begin
               // A reversal starts a new ramp immediately from the live GAP value.
               gap_d   = GAP;
               cnt_d   = GAP;
               lvl_d   = lvl_q - LVL_ONE;
               state_d = (lvl_q == LVL_ONE) ? IDLE : DOWN;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - GAP_W'(1);
            end else if (lvl_q == LVL_PEN) begin
               lvl_d   = LVL_TOP;
               state_d = ON;
            end else begin
               lvl_d = lvl_q + LVL_ONE;
               cnt_d = gap_q;
            end
            ON: if (!EN) begin
               state_d = DOWN;
               lvl_d   = LVL_PEN;
               gap_d   = GAP;
               cnt_d   = GAP;
            end
            DOWN: if (EN) begin
               gap_d   = GAP;
               cnt_d   = GAP;
               lvl_d   = lvl_q + LVL_ONE;
               state_d = (lvl_q == LVL_PEN) ? ON : UP;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - GAP_W'(1);
            end else if (lvl_q == LVL_ONE) begin
               lvl_d   = '0;
               state_d = IDLE;
            end else begin
               lvl_d = lvl_q - LVL_ONE;
               cnt_d = gap_q;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so they land in registers.
   always_comb begin
      oe_d = '0;
      for (int i = 0; i < N_GRP; i++) begin
         oe_d[i] = (LW'(i) < lvl_d);
      end
      busy_d  = (state_d == UP) || (state_d == DOWN);
      ready_d = (state_d == ON);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         lvl_q   <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
         oe_q    <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lvl_q   <= lvl_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         oe_q    <= oe_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

   assign OE    = oe_q;
   assign BUSY  = busy_q;
   assign READY = ready_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__buf_drive_seq.sv
// Bench for the staggered output-enable sequencer: directed scenarios with fixed
// expected values, then random traffic against a target-seeking level model.
module tb_gf180mcu_fd_sc_mcu9t5v0__buf_drive_seq;

   localparam int N = 4;

   logic       clk;
   logic       rstIn;
   logic       enIn;
   logic       foIn;
   logic [7:0] gapIn;
   logic [N-1:0] oe;
   logic       busy;
   logic       ready;
   wire        vdd;
   wire        vss;

   assign vdd = 1'b1;
   assign vss = 1'b0;

   int errors = 0;
   int checks = 0;

   // Model: the level walks toward a target (N when EN, else 0) one group at a time.
   int mLvl  = 0;
   int mDir  = 0;
   int mWait = 0;
   int mGap  = 0;

   gf180mcu_fd_sc_mcu9t5v0__buf_drive_seq #(.N_GRP(N), .GAP_W(8)) dut (
      .CLK(clk),
      .RST(rstIn),
      .VDD(vdd),
      .VSS(vss),
      .EN(enIn),
      .FORCE_OFF(foIn),
      .GAP(gapIn),
      .OE(oe),
      .BUSY(busy),
      .READY(ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic modelStep();
      int target;
      int want;
      if (rstIn) begin
         mLvl = 0; mDir = 0; mWait = 0; mGap = 0;
      end else if (foIn) begin
         mLvl = 0; mDir = 0;
      end else begin
         target = enIn ? N : 0;
         if (mLvl != target) begin
            want = (target > mLvl) ? 1 : -1;
            if (mDir != want) begin
               mDir  = want;
               mGap  = int'(gapIn);
               mLvl  = mLvl + want;
               mWait = mGap + 1;
            end else begin
               mWait = mWait - 1;
               if (mWait == 0) begin
                  mLvl  = mLvl + mDir;
                  mWait = mGap + 1;
               end
            end
            if (mLvl == target) mDir = 0;
         end
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic en, input logic fo, input logic [7:0] gap);
      rstIn = rst;
      enIn  = en;
      foIn  = fo;
      gapIn = gap;
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic checkConst(input string tag, input logic [N-1:0] expOe, input logic expBusy, input logic expReady);
      checks++;
      assert (oe === expOe) else begin
         errors++;
         $error("[TB] FAIL %s oe: got %b expected %b", tag, oe, expOe);
      end
      checks++;
      assert (busy === expBusy) else begin
         errors++;
         $error("[TB] FAIL %s busy: got %b expected %b", tag, busy, expBusy);
      end
      checks++;
      assert (ready === expReady) else begin
         errors++;
         $error("[TB] FAIL %s ready: got %b expected %b", tag, ready, expReady);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [N-1:0] expOe;
      expOe = N'((1 << mLvl) - 1);
      checkConst(tag, expOe, (mDir != 0), (mLvl == N));
      checks++;
      assert ((oe & (oe + 1'b1)) === '0) else begin
         errors++;
         $error("[TB] FAIL %s thermometer: got %b expected thermometer code", tag, oe);
      end
   endtask

   initial begin
      rstIn = 1'b1; enIn = 1'b0; foIn = 1'b0; gapIn = '0;

      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 1, 0, 5);
      checkConst("reset", 4'b0000, 0, 0);
      applyStimulus(0, 0, 0, 3);
      checkOutput("idle");

      // Up ramp with GAP=2, then hold ON and ramp down from edge 20.
      applyStimulus(0, 1, 0, 2);
      checkConst("up e0", 4'b0001, 1, 0);
      for (int e = 1; e <= 29; e++) begin
         applyStimulus(0, (e < 20), 0, 2);
         checkOutput("gap2 ramp");
         if (e == 3)  checkConst("up e3", 4'b0011, 1, 0);
         if (e == 6)  checkConst("up e6", 4'b0111, 1, 0);
         if (e == 9)  checkConst("up e9", 4'b1111, 0, 1);
         if (e == 20) checkConst("dn e20", 4'b0111, 1, 0);
         if (e == 23) checkConst("dn e23", 4'b0011, 1, 0);
         if (e == 26) checkConst("dn e26", 4'b0001, 1, 0);
         if (e == 29) checkConst("dn e29", 4'b0000, 0, 0);
      end

      // Reversal mid up-ramp with GAP=1.
      for (int e = 0; e <= 5; e++) begin
         applyStimulus(0, (e < 3), 0, 1);
         checkOutput("reverse");
         if (e == 2) checkConst("rev e2", 4'b0011, 1, 0);
         if (e == 3) checkConst("rev e3", 4'b0001, 1, 0);
         if (e == 5) checkConst("rev e5", 4'b0000, 0, 0);
      end

      // FORCE_OFF at edge 4 of an up-ramp while EN stays high.
      for (int e = 0; e <= 5; e++) begin
         applyStimulus(0, 1, (e == 4), 2);
         checkOutput("force");
         if (e == 4) checkConst("force e4", 4'b0000, 0, 0);
         if (e == 5) checkConst("force e5", 4'b0001, 1, 0);
      end
      for (int e = 0; e < 20; e++) applyStimulus(0, 0, 0, 0);
      checkConst("force idle", 4'b0000, 0, 0);

      // GAP=0 ramp, GAP moved to 7 mid-ramp; down-ramp then spaces by 8.
      for (int e = 0; e <= 28; e++) begin
         applyStimulus(0, (e < 4), 0, (e < 2) ? 8'd0 : 8'd7);
         checkOutput("gapchg");
         if (e == 3)  checkConst("gapchg e3", 4'b1111, 0, 1);
         if (e == 4)  checkConst("gapchg e4", 4'b0111, 1, 0);
         if (e == 11) checkConst("gapchg e11", 4'b0111, 1, 0);
         if (e == 12) checkConst("gapchg e12", 4'b0011, 1, 0);
         if (e == 20) checkConst("gapchg e20", 4'b0001, 1, 0);
         if (e == 28) checkConst("gapchg e28", 4'b0000, 0, 0);
      end

      // RST at edge 5 of a ramp with EN held.
      for (int e = 0; e <= 6; e++) begin
         applyStimulus((e == 5), 1, 0, 2);
         checkOutput("rst mid");
         if (e == 5) checkConst("rst e5", 4'b0000, 0, 0);
         if (e == 6) checkConst("rst e6", 4'b0001, 1, 0);
      end
      for (int e = 0; e < 20; e++) applyStimulus(0, 0, 0, 0);

      // Maximum spacing must not overflow the counter.
      for (int e = 0; e <= 256; e++) begin
         applyStimulus(0, 1, 0, 8'hFF);
         if (e == 255) checkConst("gapmax e255", 4'b0001, 1, 0);
         if (e == 256) checkConst("gapmax e256", 4'b0011, 1, 0);
      end
      applyStimulus(1, 0, 0, 0);
      checkOutput("gapmax rst");

      // Random traffic: slow EN changes, small gaps, rare force-off and reset.
      for (int e = 0; e < 3000; e++) begin
         logic en;
         logic fo;
         logic rs;
         logic [7:0] gap;
         en  = ($urandom_range(0, 15) == 0) ? ~enIn : enIn;
         fo  = ($urandom_range(0, 63) == 0);
         rs  = ($urandom_range(0, 127) == 0);
         gap = 8'($urandom_range(0, 3));
         applyStimulus(rs, en, fo, gap);
         checkOutput("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
